// File: rtl/uart_cmd_frame_tx_pkg.sv
// Shared command-frame definitions for the host serial transmitter and the
// receive-side command checker.
package uart_cmd_frame_tx_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'b00,
    CMD_RF_RD   = 2'b01,
    CMD_ALU_OPS = 2'b10,
    CMD_ALU_NOP = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } frame_state_e;

  function automatic logic [7:0] opcode_of(input cmd_type_e t);
    case (t)
      CMD_RF_WR:   return OP_RF_WR;
      CMD_RF_RD:   return OP_RF_RD;
      CMD_ALU_OPS: return OP_ALU_OPS;
      default:     return OP_ALU_NOP;
    endcase
  endfunction

  // Index of the final byte in the frame (byte count minus one).
  function automatic logic [1:0] last_idx_of(input cmd_type_e t);
    case (t)
      CMD_RF_WR:   return 2'd2;
      CMD_ALU_OPS: return 2'd3;
      default:     return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_frame_tx_bit_tick_gen.sv
// Bit-period timer: one-cycle tick on the last clock of every CLKS_PER_BIT
// period, realigned to a fresh period by restart.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Command serializer: expands one descriptor into a 2-4 byte command frame and
// shifts it out as UART characters with optional parity and inter-byte gaps.
module uart_cmd_frame_tx
  import uart_cmd_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32,
  parameter int GAP_BITS     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_TYPE,
  input  logic [7:0] CMD_B1,
  input  logic [7:0] CMD_B2,
  input  logic [7:0] CMD_B3,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_LINE,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  frame_state_e     state_q, state_n;
  logic [3:0]       bit_cnt_q, bit_cnt_n;
  logic [1:0]       byte_idx_q, byte_idx_n;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;

  cmd_type_e        type_q;
  logic [7:0]       b1_q, b2_q, b3_q;
  logic             par_en_q, par_typ_q;

  logic             accept;
  logic             tick;
  logic [7:0]       cur_byte;

  assign CMD_READY  = (state_q == ST_IDLE);
  assign BUSY       = (state_q != ST_IDLE);
  assign TX_LINE    = tx_q;
  assign FRAME_DONE = done_q;
  assign accept     = CMD_VALID && CMD_READY;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (CLK),
    .rst    (RST),
    .restart(accept),
    .tick   (tick)
  );

  // Descriptor capture: held for the whole frame so live inputs cannot leak in.
  always_ff @(posedge CLK) begin
    if (accept) begin
      type_q    <= cmd_type_e'(CMD_TYPE);
      b1_q      <= CMD_B1;
      b2_q      <= CMD_B2;
      b3_q      <= CMD_B3;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  always_comb begin
    cur_byte = opcode_of(type_q);
    case (byte_idx_q)
      2'd1:    cur_byte = b1_q;
      2'd2:    cur_byte = b2_q;
      2'd3:    cur_byte = b3_q;
      default: cur_byte = opcode_of(type_q);
    endcase
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    byte_idx_n = byte_idx_q;
    gap_cnt_n  = gap_cnt_q;
    done_n     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_n    = ST_START;
          bit_cnt_n  = '0;
          byte_idx_n = '0;
          gap_cnt_n  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 4'd7) begin
            state_n = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_n = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_idx_q == last_idx_of(type_q)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            byte_idx_n = byte_idx_q + 2'd1;
            gap_cnt_n  = '0;
            state_n    = (GAP_BITS == 0) ? ST_START : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_n = ST_START;
          end else begin
            gap_cnt_n = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the output flop changes
  // exactly on bit boundaries.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = cur_byte[bit_cnt_n[2:0]];
      ST_PARITY: tx_n = (^cur_byte) ^ par_typ_q;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      byte_idx_q <= byte_idx_n;
      gap_cnt_q  <= gap_cnt_n;
      tx_q       <= tx_n;
      done_q     <= done_n;
    end
  end

endmodule
